inst_queue: RTL and testbench

Instruction buffer between instruction fetch and the decode/control stage of the RISC-V mini pipeline. Accepts fetched {pc, instruction} pairs over a valid/ready handshake and stores them in a small in-order FIFO. Presents the head entry to decode with opcode, funct3, funct7 and register fields already split out. Supports a single-cycle flush for redirects (branch/jump).

---
 rtl/inst_queue_pkg.sv | 46 ++++
 rtl/inst_queue_mem.sv | 25 ++
 rtl/inst_queue.sv | 107 ++++++++++
 tb/tb_inst_queue.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared RISC-V instruction field positions, NOP encoding and major opcodes
// used by the instruction queue and the control decoder.
package inst_queue_pkg;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

    // ADDI x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } inst_fields_t;

    function automatic inst_fields_t split_inst(input logic [31:0] inst);
        inst_fields_t f;
        f.opcode = inst[OPCODE_MSB:OPCODE_LSB];
        f.rd     = inst[RD_MSB:RD_LSB];
        f.funct3 = inst[FUNCT3_MSB:FUNCT3_LSB];
        f.rs1    = inst[RS1_MSB:RS1_LSB];
        f.rs2    = inst[RS2_MSB:RS2_LSB];
        f.funct7 = inst[FUNCT7_MSB:FUNCT7_LSB];
        return f;
    endfunction

endpackage

// File: rtl/inst_queue_mem.sv
// Instruction queue storage: DEPTH x W register array, one synchronous write
// port and one asynchronous read port. Contents are not reset.
module inst_queue_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_queue.sv
// In-order instruction buffer between fetch and decode with flush and field split.
// Optional same-cycle empty-queue bypass enabled by defining INST_QUEUE_BYPASS_EN.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [31:0]                in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_inst,
    output logic [6:0]                 out_opcode,
    output logic [2:0]                 out_funct3,
    output logic [6:0]                 out_funct7,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int W     = XLEN + 32;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [W-1:0]     head;
    logic             byp, push, pop, wr_en, rd_en;
    inst_fields_t     fields;

    inst_queue_mem #(.DEPTH(DEPTH), .W(W)) u_mem (
        .clock (clock),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata ({in_pc, in_inst}),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    always_comb begin
        byp = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
        byp = (count_q == '0) && in_valid && !flush;
`endif
        in_ready  = (count_q != CNT_W'(DEPTH));
        out_valid = (count_q != '0) || byp;
        if (byp) begin
            {out_pc, out_inst} = {in_pc, in_inst};
        end else if (count_q != '0) begin
            {out_pc, out_inst} = head;
        end else begin
            out_pc   = '0;
            out_inst = NOP_INST;
        end
    end

    // A bypassed entry that decode takes immediately never touches storage.
    always_comb begin
        push  = in_valid && in_ready && !flush;
        pop   = out_valid && out_ready && !flush;
        wr_en = push && !(byp && out_ready);
        rd_en = pop && !byp;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign fields     = split_inst(out_inst);
    assign out_opcode = fields.opcode;
    assign out_funct3 = fields.funct3;
    assign out_funct7 = fields.funct7;
    assign out_rd     = fields.rd;
    assign out_rs1    = fields.rs1;
    assign out_rs2    = fields.rs2;
    assign count      = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: vector table, FIFO scoreboard and
// hand-written flush / async reset / bypass sequences.
module tb_inst_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_pc = '0, in_inst = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_inst;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb[$];

    inst_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .count(count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic model_byp();
`ifdef INST_QUEUE_BYPASS_EN
        return (sb.size() == 0) && in_valid && !flush;
`else
        return 1'b0;
`endif
    endfunction

    // Apply inputs, settle, then compare every output against the scoreboard.
    task automatic drive(input logic fl, input logic iv, input logic [31:0] pc,
                         input logic [31:0] inst, input logic ordy);
        logic [63:0] e;
        flush = fl; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
        #1;
        if (model_byp()) e = {in_pc, in_inst};
        else if (sb.size() != 0) e = sb[0];
        else e = {32'h0, 32'h0000_0013};
        check("sb_count", 64'(count), 64'(sb.size()));
        check("sb_in_ready", 64'(in_ready), 64'(sb.size() != DEPTH));
        check("sb_out_valid", 64'(out_valid), 64'((sb.size() != 0) || model_byp()));
        check("sb_out_pc_inst", {out_pc, out_inst}, e);
        check("sb_fields", 64'({out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode}),
              64'(e[31:0]));
    endtask

    // Advance the scoreboard with the applied inputs and clock one edge.
    task automatic tick();
        logic rdy, vld, byp;
        rdy = (sb.size() != DEPTH);
        byp = model_byp();
        vld = (sb.size() != 0) || byp;
        if (flush) begin
            sb.delete();
        end else if (byp) begin
            if (!out_ready) sb.push_back({in_pc, in_inst});
        end else begin
            if (vld && out_ready) void'(sb.pop_front());
            if (in_valid && rdy) sb.push_back({in_pc, in_inst});
        end
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ordy;
        int          e_cnt;
        logic        e_vld;
        logic        e_rdy;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 32'h0,  32'h002081B3, 1'b0, 0, 1'b0, 1'b1, 32'h00000013};
`ifdef INST_QUEUE_BYPASS_EN
        vecs[0] = '{1'b1, 32'h0,  32'h002081B3, 1'b0, 0, 1'b1, 1'b1, 32'h002081B3};
`endif
        vecs[1] = '{1'b1, 32'h4,  32'h00500093, 1'b0, 1, 1'b1, 1'b1, 32'h002081B3};
        vecs[2] = '{1'b1, 32'h8,  32'h0000A103, 1'b0, 2, 1'b1, 1'b1, 32'h002081B3};
        vecs[3] = '{1'b1, 32'hC,  32'h0020A023, 1'b0, 3, 1'b1, 1'b1, 32'h002081B3};
        vecs[4] = '{1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 4, 1'b1, 1'b0, 32'h002081B3};
        vecs[5] = '{1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 4, 1'b1, 1'b0, 32'h002081B3};
        vecs[6] = '{1'b0, 32'h0,  32'h0,        1'b1, 3, 1'b1, 1'b1, 32'h00500093};
        vecs[7] = '{1'b0, 32'h0,  32'h0,        1'b1, 2, 1'b1, 1'b1, 32'h0000A103};
        vecs[8] = '{1'b0, 32'h0,  32'h0,        1'b1, 1, 1'b1, 1'b1, 32'h0020A023};
        vecs[9] = '{1'b0, 32'h0,  32'h0,        1'b0, 0, 1'b0, 1'b1, 32'h00000013};

        // Reset then idle
        #2;
        check("rst_count", 64'(count), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_inst", 64'(out_inst), 64'h13);
        check("rst_out_opcode", 64'(out_opcode), 64'h13);
        @(posedge clock); #1;
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0); tick();

        // Fill to full (5th offer refused), then drain in order
        for (int i = 0; i < 10; i++) begin
            drive(0, vecs[i].iv, vecs[i].pc, vecs[i].inst, vecs[i].ordy);
            check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].e_vld));
            check($sformatf("vec%0d_ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
            check($sformatf("vec%0d_inst", i), 64'(out_inst), 64'(vecs[i].e_inst));
            if (i == 1) begin
                check("head_opcode", 64'(out_opcode), 64'h33);
                check("head_funct3", 64'(out_funct3), 64'h0);
                check("head_funct7", 64'(out_funct7), 64'h0);
                check("head_rd", 64'(out_rd), 64'd3);
                check("head_rs1", 64'(out_rs1), 64'd1);
                check("head_rs2", 64'(out_rs2), 64'd2);
                check("head_pc", 64'(out_pc), 64'h0);
            end
            tick();
        end

        // Fill to 2, then 10 cycles of simultaneous push and pop
        drive(0, 1, 32'h100, 32'h00100013, 0); tick();
        drive(0, 1, 32'h104, 32'h00200013, 0); tick();
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 32'h108 + 32'(4 * k), 32'h00300013 + 32'(k << 7), 1);
            check("stream_count", 64'(count), 64'd2);
            check("stream_pc", 64'(out_pc), 64'(32'h100 + 32'(4 * k)));
            tick();
        end
        drive(0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0);
        check("stream_drained", 64'(count), 64'd0);
        tick();

        // Flush with count=3 while fetch offers and decode consumes
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 32'h400 + 32'(4 * k), 32'h00400013, 0); tick();
        end
        drive(1, 1, 32'h500, 32'h00500013, 1);
        check("pre_flush_count", 64'(count), 64'd3);
        tick();
        drive(0, 0, 0, 0, 0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        tick();
        drive(0, 1, 32'h600, 32'h00600013, 0); tick();
        drive(0, 0, 0, 0, 1);
        check("post_flush_pc", 64'(out_pc), 64'h600);
        tick();

        // Async reset between edges with count=2
        drive(0, 1, 32'h700, 32'h00700013, 0); tick();
        drive(0, 1, 32'h704, 32'h00800013, 0); tick();
        drive(0, 0, 0, 0, 0);
        check("pre_rst_count", 64'(count), 64'd2);
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_inst", 64'(out_inst), 64'h13);
        reset_n = 1'b1;
        sb.delete();
        #1;
        tick();

        // Empty queue, offer and consume in the same cycle
        drive(0, 1, 32'h800, 32'h02208033, 1);
`ifdef INST_QUEUE_BYPASS_EN
        check("byp_valid", 64'(out_valid), 64'd1);
        check("byp_funct7", 64'(out_funct7), 64'h01);
        check("byp_pc", 64'(out_pc), 64'h800);
        tick();
        drive(0, 0, 0, 0, 1);
        check("byp_count", 64'(count), 64'd0);
        check("byp_valid_after", 64'(out_valid), 64'd0);
        tick();
`else
        check("nobyp_valid", 64'(out_valid), 64'd0);
        tick();
        drive(0, 0, 0, 0, 1);
        check("nobyp_valid_next", 64'(out_valid), 64'd1);
        check("nobyp_funct7_next", 64'(out_funct7), 64'h01);
        check("nobyp_count_next", 64'(count), 64'd1);
        tick();
        drive(0, 0, 0, 0, 0);
        check("nobyp_drained", 64'(count), 64'd0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
